// File: rtl/lif_tdm_if.sv
// Handshake bundle between the chip I/O side and the LIF TDM scheduler.
// Latency: none, wires only.
// Backpressure: in_ready/cfg_ready throttle the driver; spikes have none.
//
// Ports (master = I/O side, slave = scheduler):
//   tick                               timestep strobe
//   in_valid/in_ready/in_idx/in_weight weighted input events
//   cfg_valid/cfg_ready/cfg_addr/cfg_data  config writes
//   spike_valid/spike_idx              spike pulses
//   busy/overrun                       sweep status
interface lif_tdm_if #(
   parameter int IDX_W = 2,
   parameter int W     = 8
);
   logic             tick;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_idx;
   logic [W-1:0]     in_weight;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_addr;
   logic [W-1:0]     cfg_data;
   logic             spike_valid;
   logic [IDX_W-1:0] spike_idx;
   logic             busy;
   logic             overrun;

   modport master (
      output tick, in_valid, in_idx, in_weight, cfg_valid, cfg_addr, cfg_data,
      input  in_ready, cfg_ready, spike_valid, spike_idx, busy, overrun
   );

   modport slave (
      input  tick, in_valid, in_idx, in_weight, cfg_valid, cfg_addr, cfg_data,
      output in_ready, cfg_ready, spike_valid, spike_idx, busy, overrun
   );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Shares one leaky-integrate-and-fire datapath across N_NEURONS membranes.
// Latency: tick -> N-cycle sweep, spike for neuron p one cycle after it is processed.
// Backpressure: events/config accepted only when idle; spikes cannot be stalled.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    lif_tdm_if slave: events, config, tick, spikes, busy/overrun
module lif_tdm_scheduler #(
   parameter int N_NEURONS   = 4,
   parameter int IDX_W       = 2,
   parameter int W           = 8,
   parameter int THRESH_INIT = 128,
   parameter int LEAK_INIT   = 1
) (
   input  logic      clk,
   input  logic      reset,
   lif_tdm_if.slave  bus
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] p_q;
   logic [W-1:0]     u_q [N_NEURONS];
   logic [W-1:0]     thresh_q;
   logic [2:0]       leak_q;
   logic             spike_vld_q;
   logic [IDX_W-1:0] spike_idx_q;
   logic             overrun_q;

   // Shared sweep datapath for the neuron under the pointer.
   logic [W-1:0] u_cur;
   logic [W-1:0] leaked_d;
   logic         fire_d;

   assign u_cur    = u_q[p_q];
   // A zero shift means "no leak"; u - (u >> 0) would wrongly zero the membrane.
   assign leaked_d = (leak_q == 3'd0) ? u_cur : u_cur - (u_cur >> leak_q);
   assign fire_d   = (leaked_d >= thresh_q);

   // Event integration: one extra bit so the carry selects saturation.
   logic [W:0]   sum_d;
   logic [W-1:0] sat_d;

   assign sum_d = {1'b0, u_q[bus.in_idx]} + {1'b0, bus.in_weight};
   assign sat_d = sum_d[W] ? '1 : sum_d[W-1:0];

   assign bus.in_ready  = (state_q == IDLE) && !reset;
   assign bus.cfg_ready = (state_q == IDLE) && !reset;
   assign bus.busy      = (state_q == SWEEP) && !reset;
   // Registered outputs are masked so they read zero in the reset cycle itself.
   assign bus.spike_valid = spike_vld_q && !reset;
   assign bus.spike_idx   = reset ? '0 : spike_idx_q;
   assign bus.overrun     = overrun_q && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         p_q         <= '0;
         for (int i = 0; i < N_NEURONS; i++) u_q[i] <= '0;
         thresh_q    <= W'(THRESH_INIT);
         leak_q      <= 3'(LEAK_INIT);
         spike_vld_q <= 1'b0;
         spike_idx_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         spike_vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.in_valid) u_q[bus.in_idx] <= sat_d;
               if (bus.cfg_valid) begin
                  case (bus.cfg_addr)
                     2'd0: thresh_q <= bus.cfg_data;
                     2'd1: leak_q   <= bus.cfg_data[2:0];
                     // Placed after the event write so the clear wins a collision.
                     2'd2: for (int i = 0; i < N_NEURONS; i++) u_q[i] <= '0;
                     default: ;
                  endcase
               end
               if (bus.tick) begin
                  state_q <= SWEEP;
                  p_q     <= '0;
               end
            end
            SWEEP: begin
               u_q[p_q] <= fire_d ? '0 : leaked_d;
               if (fire_d) begin
                  spike_vld_q <= 1'b1;
                  spike_idx_q <= p_q;
               end
               if (bus.tick) overrun_q <= 1'b1;
               if (p_q == IDX_W'(N_NEURONS - 1)) begin
                  state_q <= IDLE;
                  p_q     <= '0;
               end else begin
                  p_q <= p_q + IDX_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench for lif_tdm_scheduler: directed scenarios plus a
// randomized phase checked against a timestep-level reference model.
module tb_lif_tdm_scheduler;
   localparam int N     = 4;
   localparam int IDX_W = 2;
   localparam int W     = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lif_tdm_if #(.IDX_W(IDX_W), .W(W)) bus();

   lif_tdm_scheduler #(
      .N_NEURONS(N), .IDX_W(IDX_W), .W(W), .THRESH_INIT(128), .LEAK_INIT(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: whole membranes as plain integers.
   int m_u [N];
   int m_th;
   int m_leak;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.tick      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_idx    = '0;
      bus.in_weight = '0;
      bus.cfg_valid = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < N; i++) m_u[i] = 0;
      m_th   = 128;
      m_leak = 1;
   endtask

   // One idle-cycle's worth of inputs, then (if ticked) a whole timestep at once.
   task automatic mdl_apply(input int ev, input int idx, input int w, input int cv,
                            input int addr, input int data, input int tk, output int mask);
      int l;
      mask = 0;
      if (cv != 0) begin
         if (addr == 0) m_th = data;
         else if (addr == 1) m_leak = data % 8;
         else if (addr == 2) for (int i = 0; i < N; i++) m_u[i] = 0;
      end
      if (ev != 0 && !(cv != 0 && addr == 2))
         m_u[idx] = (m_u[idx] + w > 255) ? 255 : m_u[idx] + w;
      if (tk != 0) begin
         for (int i = 0; i < N; i++) begin
            l = (m_leak == 0) ? m_u[i] : m_u[i] - (m_u[i] / (1 << m_leak));
            if (l >= m_th) begin
               mask = mask | (1 << i);
               m_u[i] = 0;
            end else begin
               m_u[i] = l;
            end
         end
      end
   endtask

   // Called in cycle T+1. Junk events/clears are offered throughout the sweep;
   // they must be refused.
   task automatic do_sweep(input int mask, input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 1);
      chk({tag, "_rdy_sweep"}, 32'(bus.in_ready), 0);
      chk({tag, "_spk_t1"}, 32'(bus.spike_valid), 0);
      bus.in_valid  = 1'b1;
      bus.in_idx    = IDX_W'($urandom_range(0, N - 1));
      bus.in_weight = 8'd255;
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = 2'd2;
      for (int k = 2; k <= N + 1; k++) begin
         step();
         if (k == N + 1) idle_inputs();
         chk({tag, "_spk_vld"}, 32'(mask[k-2]), 32'(bus.spike_valid));
         if (mask[k-2]) chk({tag, "_spk_idx"}, 32'(bus.spike_idx), 32'(k - 2));
      end
      chk({tag, "_rdy_end"}, 32'(bus.in_ready), 1);
      chk({tag, "_busy_end"}, 32'(bus.busy), 0);
   endtask

   // exp_mask < 0 uses the reference model's spike set.
   task automatic cyc(input int ev, input int idx, input int w, input int cv,
                      input int addr, input int data, input int tk,
                      input int exp_mask, input string tag);
      int m;
      if (ev != 0) chk({tag, "_in_rdy"}, 32'(bus.in_ready), 1);
      if (cv != 0) chk({tag, "_cfg_rdy"}, 32'(bus.cfg_ready), 1);
      bus.in_valid  = 1'(ev);
      bus.in_idx    = IDX_W'(idx);
      bus.in_weight = W'(w);
      bus.cfg_valid = 1'(cv);
      bus.cfg_addr  = 2'(addr);
      bus.cfg_data  = W'(data);
      bus.tick      = 1'(tk);
      mdl_apply(ev, idx, w, cv, addr, data, tk, m);
      step();
      idle_inputs();
      if (tk != 0) do_sweep((exp_mask < 0) ? m : exp_mask, tag);
      else chk({tag, "_no_spk"}, 32'(bus.spike_valid), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      mdl_reset();

      // Reset defaults.
      for (int r = 0; r < 2; r++) begin
         step();
         chk("rst_in_rdy", 32'(bus.in_ready), 0);
         chk("rst_cfg_rdy", 32'(bus.cfg_ready), 0);
         chk("rst_busy", 32'(bus.busy), 0);
         chk("rst_spk_vld", 32'(bus.spike_valid), 0);
         chk("rst_spk_idx", 32'(bus.spike_idx), 0);
         chk("rst_overrun", 32'(bus.overrun), 0);
      end
      reset = 1'b0;
      #1;
      chk("rel_in_rdy", 32'(bus.in_ready), 1);
      chk("rel_cfg_rdy", 32'(bus.cfg_ready), 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, "rst_tick");

      // Integrate and fire: 60 + 50 = 110 >= 100.
      cyc(0, 0, 0, 1, 0, 100, 0, -1, "if_th");
      cyc(0, 0, 0, 1, 1, 0, 0, -1, "if_leak");
      cyc(1, 1, 60, 0, 0, 0, 0, -1, "if_ev1");
      cyc(1, 1, 50, 0, 0, 0, 0, -1, "if_ev2");
      cyc(0, 0, 0, 0, 0, 0, 1, 'b0010, "if_tick1");
      cyc(0, 0, 0, 0, 0, 0, 1, 'b0000, "if_tick2");

      // Leak: 160 -> 80 -> 40.
      cyc(0, 0, 0, 1, 1, 1, 0, -1, "lk_leak");
      cyc(0, 0, 0, 1, 0, 200, 0, -1, "lk_th");
      cyc(1, 2, 160, 0, 0, 0, 0, -1, "lk_ev");
      cyc(0, 0, 0, 0, 0, 0, 1, 0, "lk_tick1");
      chk("lk_u2_80", 32'(dut.u_q[2]), 80);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, "lk_tick2");
      chk("lk_u2_40", 32'(dut.u_q[2]), 40);

      // Saturation: 200 + 200 clips at 255.
      cyc(0, 0, 0, 1, 0, 255, 0, -1, "sat_th");
      cyc(0, 0, 0, 1, 1, 0, 0, -1, "sat_leak");
      cyc(1, 0, 200, 0, 0, 0, 0, -1, "sat_ev1");
      cyc(1, 0, 200, 0, 0, 0, 0, -1, "sat_ev2");
      chk("sat_u0", 32'(dut.u_q[0]), 255);
      cyc(0, 0, 0, 0, 0, 0, 1, 'b0001, "sat_tick");

      // Collisions: event with tick, then clear with event.
      cyc(1, 3, 255, 0, 0, 0, 1, 'b1000, "col_ev_tick");
      cyc(1, 0, 255, 1, 2, 0, 0, -1, "col_clr_ev");
      chk("col_clr_u0", 32'(dut.u_q[0]), 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, "col_clr_tick");

      // Overrun and reset mid-sweep with every neuron primed.
      cyc(0, 0, 0, 1, 0, 10, 0, -1, "ovr_th");
      for (int i = 0; i < N; i++) cyc(1, i, 50, 0, 0, 0, 0, -1, "ovr_prime");
      chk("ovr_pre", 32'(bus.overrun), 0);
      bus.tick = 1'b1;
      step();            // T+1
      bus.tick = 1'b0;
      step();            // T+2
      bus.tick = 1'b1;
      step();            // T+3
      bus.tick = 1'b0;
      chk("ovr_set", 32'(bus.overrun), 1);
      chk("ovr_busy", 32'(bus.busy), 1);
      chk("ovr_spk_idx", 32'(bus.spike_idx), 1);
      reset = 1'b1;
      #1;
      chk("ovr_rst_spk", 32'(bus.spike_valid), 0);
      chk("ovr_rst_ovr", 32'(bus.overrun), 0);
      chk("ovr_rst_rdy", 32'(bus.in_ready), 0);
      step();            // T+4
      reset = 1'b0;
      mdl_reset();
      #1;
      for (int k = 0; k < N; k++) begin
         chk("ovr_post_spk", 32'(bus.spike_valid), 0);
         chk("ovr_post_ovr", 32'(bus.overrun), 0);
         chk("ovr_post_busy", 32'(bus.busy), 0);
         step();
      end
      cyc(0, 0, 0, 0, 0, 0, 1, 0, "ovr_after_tick");

      // Randomized traffic against the reference model.
      for (int it = 0; it < 300; it++) begin
         int ev, idx, w, cv, addr, data, tk;
         ev   = int'($urandom_range(0, 1));
         idx  = int'($urandom_range(0, N - 1));
         w    = int'($urandom_range(0, 255));
         cv   = ($urandom_range(0, 3) == 0) ? 1 : 0;
         addr = int'($urandom_range(0, 3));
         data = int'($urandom_range(0, 255));
         tk   = ($urandom_range(0, 4) == 0) ? 1 : 0;
         cyc(ev, idx, w, cv, addr, data, tk, -1, "rnd");
      end
      for (int i = 0; i < N; i++) chk("rnd_final_u", 32'(dut.u_q[i]), 32'(m_u[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lif_tdm_scheduler.md
# lif_tdm_scheduler

Time-multiplexed scheduler that shares one leaky-integrate-and-fire update datapath among `N_NEURONS` neurons whose membrane potentials sit in an internal register file. It accepts weighted input events over a valid/ready handshake, and on each `tick` it sweeps every neuron once, applying leak, threshold and reset-to-zero. It emits one spike pulse per firing neuron. It sits between the chip I/O pins and the neuron state, and extends the single-neuron tile to a small population without duplicating arithmetic.

## Interface
- `N_NEURONS`, 4: neurons served; power of two, 2..16.
- `IDX_W`, 2: index width, equal to log2(`N_NEURONS`).
- `W`, 8: membrane, weight and threshold width, unsigned.
- `THRESH_INIT`, 128: threshold after reset.
- `LEAK_INIT`, 1: leak shift after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  timestep strobe, one cycle wide.
- `in_valid`  in  1  an input event is offered.
- `in_ready`  out  1  the scheduler can accept an event.
- `in_idx`  in  IDX_W  target neuron.
- `in_weight`  in  W  amount to add to the target membrane.
- `cfg_valid`  in  1  a config write is offered.
- `cfg_ready`  out  1  the scheduler can accept a config write.
- `cfg_addr`  in  2  config register: 0 = threshold, 1 = leak shift (bits [2:0] of `cfg_data`), 2 = clear all membranes, 3 = no-op.
- `cfg_data`  in  W  config write data.
- `spike_valid`  out  1  one-cycle spike pulse; there is no backpressure.
- `spike_idx`  out  IDX_W  index of the neuron that fired.
- `busy`  out  1  high while a sweep is in progress.
- `overrun`  out  1  sticky; set when a `tick` arrives during a sweep.

## Operation
- Two states, IDLE and SWEEP.
  - IDLE to SWEEP: `tick` is sampled high in IDLE; the sweep pointer `p` is set to 0.
  - SWEEP to IDLE: after the cycle that processes `p = N_NEURONS-1`.
- **Reset** takes precedence over every other input:
  - all membranes = 0, threshold = `THRESH_INIT`, leak = `LEAK_INIT`;
  - state = IDLE, `p` = 0;
  - outputs `in_ready`, `cfg_ready`, `busy`, `spike_valid`, `spike_idx` and `overrun` are all 0 in the reset cycle;
  - `in_ready` and `cfg_ready` rise in the first cycle after `reset` is deasserted.
- **Handshakes:**
  - `in_ready = cfg_ready = (state == IDLE) && !reset`.
  - A transfer occurs when valid and ready are both high at a rising edge.
  - Valid is not required to wait for ready.
- **Event integration** (IDLE only): `u[in_idx] <= min(u[in_idx] + in_weight, 2^W - 1)`. The sum is computed at W+1 bits and saturates.
- **Config writes:**
  - `cfg_addr` 0: threshold `<= cfg_data`.
  - `cfg_addr` 1: leak `<= cfg_data[2:0]`.
  - `cfg_addr` 2: all `u <= 0`.
- **Sweep step for neuron `p`:**
  - `l = (leak == 0) ? u : u - (u >> leak)`.
  - If `l >= threshold`: set `u[p] <= 0` and fire.
  - Otherwise: `u[p] <= l`.
  - Threshold 0 means every neuron fires on every sweep.
- **Simultaneous events in IDLE:**
  - Event and config in the same cycle: both are accepted.
  - Clear (`cfg_addr` 2) plus event: the clear wins and the event is consumed and lost.
  - Event plus `tick`: the event is accepted and integrated before the sweep begins.
  - Config write plus `tick`: the new value applies to that same sweep.
  - A single event that saturates a membrane and also crosses threshold fires on the next sweep, not immediately.
- **Overrun:** a `tick` in SWEEP is ignored and sets `overrun`, which is cleared only by `reset`.
- **Reset mid-sweep:** the sweep aborts and no further spikes are emitted.

## Timing
- `tick` high at cycle T (state IDLE):
  - cycles T+1 .. T+N: SWEEP, processing neurons 0 .. N-1 in order, with `busy` = 1;
  - cycle T+N+1: IDLE, with `in_ready` = 1.
- Spike latency: the neuron processed in cycle C drives `spike_valid` = 1 and `spike_idx` = p in cycle C+1.
  - Spikes therefore appear in cycles T+2 .. T+N+1, in ascending index order.
  - `spike_idx` holds its last value while `spike_valid` = 0.
- Event latency: an event accepted at edge E is visible in `u` after E, so a `tick` in the same cycle includes it.
- Throughput: one event per cycle in IDLE; a full timestep costs N+1 cycles minimum between ticks.
- `spike_valid` and `spike_idx` are registered outputs; `in_ready`, `cfg_ready` and `busy` decode directly from state and `reset`.

## Test plan
- **Reset defaults:** hold `reset` for 2 cycles, then release → all outputs are 0 during reset, `in_ready` = 1 in the next cycle, and a `tick` with no events produces no spikes.
- **Integrate and fire:** threshold 100, leak 0; events (n1, 60) and (n1, 50); then `tick` → exactly one spike with `spike_idx` = 1 at T+3; a second `tick` gives no spike, proving u1 was reset to 0.
- **Leak:** leak 1, threshold 200; event (n2, 160); then 2 ticks → no spikes, and an internal probe shows u2 = 80 after the first tick and 40 after the second.
- **Saturation:** threshold 255, leak 0; events (n0, 200) and (n0, 200) → u0 = 255; `tick` gives a spike with `spike_idx` = 0 at T+2.
- **Collisions:**
  - event (n3, 255) plus `tick` in the same cycle with threshold 255, leak 0 → spike with `spike_idx` = 3 at T+5;
  - clear plus event (n0, 255) in the same cycle, then `tick` → no spike.
- **Overrun and reset:**
  - `tick` at T+2 while sweeping → `overrun` = 1, state stays SWEEP;
  - `reset` at T+3 with all neurons primed to fire → no `spike_valid` from T+4 on, `overrun` = 0.
